// File: rtl/m_ext_pkg.sv
// m_ext_pkg: shared constants, op/state encodings and op-class helpers for the
// RV32M execute unit.
// Optional feature macro (consumed by m_ext_unit): MEXT_FAST_MUL_EN.
package m_ext_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned RD_W  = 5;

  localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

  // funct3 order
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } m_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } m_state_e;

  function automatic logic op_is_div(input m_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input m_op_e op);
    return op[2] & op[1];
  endfunction

  // rs1 is treated as signed
  function automatic logic op_signed_a(input m_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic op_signed_b(input m_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/m_ext_signfix.sv
// m_ext_signfix: combinational sign handling around the unsigned iterative core.
//   acc_op, opa, opb        : op being accepted and its raw operands
//   mag_a_c, mag_b_c        : operand magnitudes fed to the iterative datapath
//   neg_a_c, neg_b_c        : effective operand signs (0 for unsigned operands)
//   fix_op, fix_neg_a/b     : latched op and signs of the op in flight
//   prod_mag/quo_mag/rem_mag: unsigned results of the final iteration
//   fix_res_c               : signed-corrected 32-bit architectural result
module m_ext_signfix
  import m_ext_pkg::*;
(
  input  logic [2:0]        acc_op,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic [XLEN-1:0]   mag_a_c,
  output logic [XLEN-1:0]   mag_b_c,
  output logic              neg_a_c,
  output logic              neg_b_c,
  input  logic [2:0]        fix_op,
  input  logic              fix_neg_a,
  input  logic              fix_neg_b,
  input  logic [2*XLEN-1:0] prod_mag,
  input  logic [XLEN-1:0]   quo_mag,
  input  logic [XLEN-1:0]   rem_mag,
  output logic [XLEN-1:0]   fix_res_c
);

  m_op_e             a_op;
  m_op_e             f_op;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  // Magnitude extraction at accept
  always_comb begin
    a_op    = m_op_e'(acc_op);
    neg_a_c = op_signed_a(a_op) & opa[XLEN-1];
    neg_b_c = op_signed_b(a_op) & opb[XLEN-1];
    mag_a_c = neg_a_c ? (XLEN'(0) - opa) : opa;
    mag_b_c = neg_b_c ? (XLEN'(0) - opb) : opb;
  end

  // Final negation: product/quotient follow sA^sB, remainder follows sA
  always_comb begin
    f_op   = m_op_e'(fix_op);
    prod_s = (fix_neg_a ^ fix_neg_b) ? ((2*XLEN)'(0) - prod_mag) : prod_mag;
    quo_s  = (fix_neg_a ^ fix_neg_b) ? (XLEN'(0) - quo_mag) : quo_mag;
    rem_s  = fix_neg_a ? (XLEN'(0) - rem_mag) : rem_mag;
    case (f_op)
      OP_MUL:                       fix_res_c = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_c = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res_c = quo_s;
      default:                      fix_res_c = rem_s;
    endcase
  end

endmodule

// File: rtl/m_ext_unit.sv
// m_ext_unit: iterative RV32M execute unit (shift-add multiply, restoring
// divide, one bit per cycle) between the CU decoder and writeback.
//   clk, rst (sync, active-high), flush (aborts in-flight op)
//   valid_in + one-hot *_en op selects, rs1_data/rs2_data operands, rd_in
//   ready_out (idle), busy (not idle), valid_out (one-cycle result pulse),
//   result, rd_out (held between pulses)
// Optional macro MEXT_FAST_MUL_EN: multiplies complete combinationally at
// accept (IDLE->DONE); divides always iterate.
module m_ext_unit
  import m_ext_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            valid_in,
  input  logic            MUL_en,
  input  logic            MULH_en,
  input  logic            MULHSU_en,
  input  logic            MULHU_en,
  input  logic            DIV_en,
  input  logic            DIVU_en,
  input  logic            REM_en,
  input  logic            REMU_en,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RD_W-1:0] rd_in,
  output logic            ready_out,
  output logic            busy,
  output logic            valid_out,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out
);

  m_state_e         state;
  m_state_e         state_nxt;
  m_op_e            acc_op;
  m_op_e            op_q;
  m_op_e            op_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             neg_a_q;
  logic             neg_a_d;
  logic             neg_b_q;
  logic             neg_b_d;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_hi_d;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  acc_lo_d;
  logic [XLEN-1:0]  opb_q;
  logic [XLEN-1:0]  opb_d;
  logic [RD_W-1:0]  rd_q;
  logic [RD_W-1:0]  rd_d;
  logic [XLEN-1:0]  result_d;
  logic [RD_W-1:0]  rd_out_d;
  logic             ready_d;
  logic             busy_d;
  logic             valid_d;

  logic             any_en;
  logic             accept;
  logic             last_iter;
  logic             ovf;
  logic             special;
  logic [XLEN-1:0]  special_res;

  logic [XLEN-1:0]  mag_a_c;
  logic [XLEN-1:0]  mag_b_c;
  logic             neg_a_c;
  logic             neg_b_c;
  logic [XLEN-1:0]  fix_res_c;

  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_shift;
  logic [XLEN-1:0]  div_diff;
  logic             div_ge;
  logic [XLEN-1:0]  hi_n;
  logic [XLEN-1:0]  lo_n;

  // Priority encode of the CU enables
  always_comb begin
    acc_op = OP_MUL;
    if      (MUL_en)    acc_op = OP_MUL;
    else if (MULH_en)   acc_op = OP_MULH;
    else if (MULHSU_en) acc_op = OP_MULHSU;
    else if (MULHU_en)  acc_op = OP_MULHU;
    else if (DIV_en)    acc_op = OP_DIV;
    else if (DIVU_en)   acc_op = OP_DIVU;
    else if (REM_en)    acc_op = OP_REM;
    else if (REMU_en)   acc_op = OP_REMU;
  end

  assign any_en    = |{MUL_en, MULH_en, MULHSU_en, MULHU_en,
                       DIV_en, DIVU_en, REM_en, REMU_en};
  assign accept    = (state == ST_IDLE) && valid_in && any_en && !flush;
  assign last_iter = (cnt == CNT_W'(XLEN - 1));

`ifdef MEXT_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a;
  logic [2*XLEN-1:0] fast_b;
  logic [2*XLEN-1:0] fast_prod;

  // Sign/zero-extended 64-bit product; the low 64 bits are exact either way
  always_comb begin
    fast_a    = {{XLEN{op_signed_a(acc_op) & rs1_data[XLEN-1]}}, rs1_data};
    fast_b    = {{XLEN{op_signed_b(acc_op) & rs2_data[XLEN-1]}}, rs2_data};
    fast_prod = fast_a * fast_b;
  end
`endif

  // Ops that finish at accept without iterating
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    ovf         = ((acc_op == OP_DIV) || (acc_op == OP_REM)) &&
                  (rs1_data == OVF_Q) && (rs2_data == '1);
    if (op_is_div(acc_op) && (rs2_data == '0)) begin
      special     = 1'b1;
      special_res = op_is_rem(acc_op) ? rs1_data : DIV0_Q;
    end else if (ovf) begin
      special     = 1'b1;
      special_res = (acc_op == OP_DIV) ? OVF_Q : '0;
    end
`ifdef MEXT_FAST_MUL_EN
    else if (!op_is_div(acc_op)) begin
      special     = 1'b1;
      special_res = (acc_op == OP_MUL) ? fast_prod[XLEN-1:0]
                                       : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One iteration: acc_hi/acc_lo hold {product hi, multiplier} for multiply
  // and {partial remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = XLEN'(div_shift - {1'b0, opb_q});
    if (op_is_div(op_q)) begin
      hi_n = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_n = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      {hi_n, lo_n} = {mul_sum, acc_lo[XLEN-1:1]};
    end
  end

  m_ext_signfix u_signfix (
    .acc_op    (acc_op),
    .opa       (rs1_data),
    .opb       (rs2_data),
    .mag_a_c   (mag_a_c),
    .mag_b_c   (mag_b_c),
    .neg_a_c   (neg_a_c),
    .neg_b_c   (neg_b_c),
    .fix_op    (op_q),
    .fix_neg_a (neg_a_q),
    .fix_neg_b (neg_b_q),
    .prod_mag  ({hi_n, lo_n}),
    .quo_mag   (lo_n),
    .rem_mag   (hi_n),
    .fix_res_c (fix_res_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (flush)          state_nxt = ST_IDLE;
        else if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the datapath and output registers
  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    acc_hi_d = acc_hi;
    acc_lo_d = acc_lo;
    opb_d    = opb_q;
    rd_d     = rd_q;
    result_d = result;
    rd_out_d = rd_out;
    ready_d  = (state_nxt == ST_IDLE);
    busy_d   = (state_nxt != ST_IDLE);
    valid_d  = (state_nxt == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (accept) begin
          op_d     = acc_op;
          cnt_d    = '0;
          neg_a_d  = neg_a_c;
          neg_b_d  = neg_b_c;
          acc_hi_d = '0;
          acc_lo_d = mag_a_c;
          opb_d    = mag_b_c;
          rd_d     = rd_in;
          if (special) begin
            result_d = special_res;
            rd_out_d = rd_in;
          end
        end
      end
      ST_CALC: begin
        if (!flush) begin
          acc_hi_d = hi_n;
          acc_lo_d = lo_n;
          cnt_d    = cnt + CNT_W'(1);
          if (last_iter) begin
            result_d = fix_res_c;
            rd_out_d = rd_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_MUL;
      cnt       <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      result    <= '0;
      rd_out    <= '0;
      ready_out <= 1'b1;
      busy      <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      op_q      <= op_d;
      cnt       <= cnt_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      acc_hi    <= acc_hi_d;
      acc_lo    <= acc_lo_d;
      opb_q     <= opb_d;
      rd_q      <= rd_d;
      result    <= result_d;
      rd_out    <= rd_out_d;
      ready_out <= ready_d;
      busy      <= busy_d;
      valid_out <= valid_d;
    end
  end

endmodule

// File: tb/tb_m_ext_unit.sv
// tb_m_ext_unit: directed + randomized bench for m_ext_unit with an
// arithmetic reference model (64-bit products, native / and %).
module tb_m_ext_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic        MUL_en, MULH_en, MULHSU_en, MULHU_en;
  logic        DIV_en, DIVU_en, REM_en, REMU_en;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        ready_out;
  logic        busy;
  logic        valid_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_vec;
  int n_err;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  m_ext_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .valid_in  (valid_in),
    .MUL_en    (MUL_en),
    .MULH_en   (MULH_en),
    .MULHSU_en (MULHSU_en),
    .MULHU_en  (MULHU_en),
    .DIV_en    (DIV_en),
    .DIVU_en   (DIVU_en),
    .REM_en    (REM_en),
    .REMU_en   (REMU_en),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .ready_out (ready_out),
    .busy      (busy),
    .valid_out (valid_out),
    .result    (result),
    .rd_out    (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_en(input logic [7:0] m);
    {REMU_en, REM_en, DIVU_en, DIV_en, MULHU_en, MULHSU_en, MULH_en, MUL_en} = m;
  endtask

  // Highest-priority op is the lowest set enable bit (MUL=bit0)
  function automatic int first_op(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] ref_result(input int op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      0: begin p = sa * sb; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin p = sa * ub; return p[63:32]; end
      3: begin p = ua * ub; return p[63:32]; end
      4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Edges between the accept edge and the first cycle showing valid_out
  function automatic int ref_latency(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 4 && b == 32'd0) return 0;
    if ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef MEXT_FAST_MUL_EN
    if (op < 4) return 0;
`endif
    return 32;
  endfunction

  task automatic run_op(input logic [7:0] en, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    int op;
    int exp_lat;
    int k;
    logic [31:0] exp;
    op      = first_op(en);
    exp     = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    @(negedge clk);
    chk("ready_before_accept", 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    set_en(en);
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    set_en(8'd0);
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'($urandom);
    @(negedge clk);
    k = 0;
    while (valid_out !== 1'b1 && k < 40) begin
      chk("ready_low_in_calc", 32'(ready_out), 32'd0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(exp_lat));
    chk("result", result, exp);
    chk("rd_out", 32'(rd_out), 32'(rd));
    chk("busy_in_done", 32'(busy), 32'd1);
    last_res = exp;
    last_rd  = rd;
    @(negedge clk);
    chk("valid_single_pulse", 32'(valid_out), 32'd0);
    chk("ready_after_done", 32'(ready_out), 32'd1);
    chk("result_hold", result, exp);
  endtask

  initial begin
    logic [7:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    int          seen;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    valid_in = 1'b0;
    set_en(8'd0);
    rs1_data = '0;
    rs2_data = '0;
    rd_in    = '0;
    last_res = '0;
    last_rd  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Directed operations
    run_op(8'h01, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run_op(8'h02, 32'h8000_0000, 32'h8000_0000, 5'd1);
    run_op(8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(8'h10, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(8'h40, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(8'h20, 32'd100, 32'd7, 5'd7);
    run_op(8'h80, 32'd100, 32'd7, 5'd8);
    run_op(8'h20, 32'd5, 32'd0, 5'd9);
    run_op(8'h80, 32'd5, 32'd0, 5'd10);
    run_op(8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op(8'h48, 32'd100, 32'd7, 5'd13);
    run_op(8'hF0, 32'd100, 32'd0, 5'd14);

    // Flush mid-divide: no pulse, outputs keep the previous result
    @(negedge clk);
    valid_in = 1'b1;
    set_en(8'h10);
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    rd_in    = 5'd20;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    set_en(8'd0);
    repeat (10) @(negedge clk);
    chk("busy_before_flush", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_ready", 32'(ready_out), 32'd1);
    chk("flush_result_hold", result, last_res);
    chk("flush_rd_hold", 32'(rd_out), 32'(last_rd));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_out === 1'b1) seen++;
    end
    chk("flush_no_pulse", 32'(seen), 32'd0);
    run_op(8'h01, 32'd3, 32'd4, 5'd21);

    // Flush in IDLE blocks accept
    @(negedge clk);
    valid_in = 1'b1;
    set_en(8'h01);
    flush    = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    set_en(8'd0);
    flush    = 1'b0;
    chk("flush_idle_busy", 32'(busy), 32'd0);
    chk("flush_idle_ready", 32'(ready_out), 32'd1);

    // Reset mid-calculation, with a competing valid_in
    @(negedge clk);
    valid_in = 1'b1;
    set_en(8'h08);
    rs1_data = 32'hDEAD_BEEF;
    rs2_data = 32'h1234_5678;
    rd_in    = 5'd30;
    @(posedge clk);
    #1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    set_en(8'd0);
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd_out", 32'(rd_out), 32'd0);
    chk("midrst_ready", 32'(ready_out), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);

    // valid_in without any enable is ignored
    @(negedge clk);
    valid_in = 1'b1;
    rs1_data = 32'd9;
    rs2_data = 32'd9;
    repeat (3) begin
      @(negedge clk);
      chk("noen_busy", 32'(busy), 32'd0);
      chk("noen_valid", 32'(valid_out), 32'd0);
    end
    valid_in = 1'b0;

    // Randomized operations, including multi-enable and corner operands
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) m = 8'($urandom_range(1, 255));
      else                           m = 8'd1 << $urandom_range(0, 7);
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 100));
        2:       a = 32'd0 - 32'($urandom_range(1, 100));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        3:       b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(m, a, b, 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/m_ext_unit.md
Name: m_ext_unit

Overview:
- Iterative RV32M execute unit, directly downstream of the CU decoder.
- Consumes the CU's one-hot MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU enables, the rs1/rs2 register-file read data and the rd index.
- Produces a 32-bit result plus rd index, with a one-cycle valid pulse, for writeback.
- Multiply uses shift-add; divide uses restoring division at one bit per cycle.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous abort of in-flight op
- valid_in  input  1  CU presents an M op this cycle
- MUL_en, MULH_en, MULHSU_en, MULHU_en, DIV_en, DIVU_en, REM_en, REMU_en  input  1 each  op select from CU
- rs1_data  input  32  operand A
- rs2_data  input  32  operand B
- rd_in  input  5  destination index
- ready_out  output  1  unit can accept (state==IDLE)
- busy  output  1  state!=IDLE
- valid_out  output  1  one-cycle result pulse
- result  output  32  result value
- rd_out  output  5  destination of result

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: state=IDLE; valid_out=0, result=0, rd_out=0, counter=0, all internal registers 0. rst overrides flush and valid_in.
- Accept: at a rising edge with valid_in && ready_out && any enable set.
  - Latch operands, op and rd_in.
  - valid_in with no enable set: ignored, stays IDLE.
  - Multiple enables set: priority MUL>MULH>MULHSU>MULHU>DIV>DIVU>REM>REMU.
- FSM: IDLE -> CALC -> DONE -> IDLE.
  - IDLE: ready_out=1. On accept go to CALC with cnt=0, or straight to DONE for special cases.
  - CALC: one iteration per edge. After 32 iterations (cnt==31 edge), apply sign fix-up, register result, go to DONE.
  - DONE: valid_out=1 for exactly one cycle; result/rd_out valid. Next edge returns to IDLE.
  - result/rd_out hold their last values otherwise.
- Latency:
  - Normal op: accept edge E0, valid_out high in cycle after E32.
  - Special case: valid_out high in cycle after E0.
  - Next accept no earlier than the edge after DONE.
- Signedness:
  - MUL/MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU/DIVU/REMU: both unsigned.
  - Signed ops iterate on magnitudes.
  - Product is negated (64-bit two's complement) if operand signs differ.
  - Quotient sign = sA^sB; remainder sign = sA.
  - MUL returns product[31:0]; MULH* return product[63:32].
- Special cases, resolved at accept, latency 1:
  - Divide by zero (rs2==0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (DIV/REM, rs1==0x80000000, rs2==0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Flush: at any edge in CALC or DONE, go to IDLE, valid_out=0 next cycle, result/rd_out unchanged. Flush in IDLE blocks accept on that edge.
- Operand inputs are don't-care after accept; changes mid-op have no effect.

Optional Feature:
- Macro MEXT_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU compute the 64-bit product combinationally at accept, go IDLE->DONE, latency 1. Divide is unchanged.
- Undefined: all multiplies iterate in CALC, latency 32.
- Flush/reset behaviour is identical either way.

Decomposition:
- Package m_ext_pkg holds:
  - XLEN and CNT_W constants.
  - m_op_e enum (3-bit, funct3 order MUL=0..REMU=7).
  - m_state_e enum (IDLE, CALC, DONE).
  - DIV0_Q=32'hFFFFFFFF, OVF_Q=32'h80000000.
- One sub-module, m_ext_signfix: combinational magnitude extraction and final negation of product/quotient/remainder, shared by mul and div paths.
- The FSM and the iterative datapath stay in m_ext_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 -> valid_out 32 cycles after accept, result=0xFFFFFFEB, rd_out=5; ready_out low throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each valid_out one cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- DIV started, flush at iteration 10 -> no valid_out, ready_out=1 next cycle; a new MUL 3x4 is then accepted -> 12.
- rst asserted mid-CALC -> next cycle valid_out=0, result=0, ready_out=1; valid_in with all enables 0 -> no accept, busy stays 0.
